// File: rtl/alu_issue_if.sv
// Handshake and operand bus between decode, the ALU issue register and EX.
// The slave modport is the issue stage's view; master is the surrounding pipeline.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] ex_mem_res;
    logic [XLEN-1:0] mem_wb_res;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      ALU_operation;
    logic [XLEN-1:0] store_data;
    logic            illegal;
    logic [31:0]     issue_count;

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5, pc, imm,
               rs1_data, rs2_data, fwd_a_sel, fwd_b_sel, ex_mem_res, mem_wb_res,
               out_ready,
        output in_ready, out_valid, A, B, ALU_operation, store_data, illegal,
               issue_count
    );

    modport master (
        output flush, in_valid, opcode, funct3, funct7_5, pc, imm,
               rs1_data, rs2_data, fwd_a_sel, fwd_b_sel, ex_mem_res, mem_wb_res,
               out_ready,
        input  in_ready, out_valid, A, B, ALU_operation, store_data, illegal,
               issue_count
    );
endinterface

// File: rtl/alu_issue.sv
// ID/EX issue stage: RV32I ALU-op decode, operand forwarding, and a valid/ready
// holding register with stall, flush and a completed-issue counter.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7_5 selects sub only for register-register ops; immediates always add.
    function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic f75,
                                            input logic is_reg);
        case (f3)
            3'b000:  alu_func = (is_reg && f75) ? OP_SUB : OP_ADD;
            3'b001:  alu_func = OP_SLL;
            3'b010:  alu_func = OP_SLT;
            3'b011:  alu_func = OP_SLTU;
            3'b100:  alu_func = OP_XOR;
            3'b101:  alu_func = f75 ? OP_SRA : OP_SRL;
            3'b110:  alu_func = OP_OR;
            default: alu_func = OP_AND;
        endcase
    endfunction

    logic [XLEN-1:0] fa_p0, fb_p0, a_p0, b_p0;
    logic [3:0]      op_p0;
    logic            ill_p0;

    logic            vld_p1;
    logic [XLEN-1:0] a_p1, b_p1, sd_p1;
    logic [3:0]      op_p1;
    logic            ill_p1;
    logic [31:0]     issue_cnt_p1;

    logic            load_p0;
    logic            done_p1;

    // ---- p0: forwarding and decode (combinational) ----
    always_comb begin
        case (bus.fwd_a_sel)
            2'b01:   fa_p0 = bus.ex_mem_res;
            2'b10:   fa_p0 = bus.mem_wb_res;
            default: fa_p0 = bus.rs1_data;
        endcase
        case (bus.fwd_b_sel)
            2'b01:   fb_p0 = bus.ex_mem_res;
            2'b10:   fb_p0 = bus.mem_wb_res;
            default: fb_p0 = bus.rs2_data;
        endcase

        a_p0   = '0;
        b_p0   = '0;
        op_p0  = OP_ADD;
        ill_p0 = 1'b0;
        case (bus.opcode)
            OPC_R: begin
                a_p0  = fa_p0;
                b_p0  = fb_p0;
                op_p0 = alu_func(bus.funct3, bus.funct7_5, 1'b1);
            end
            OPC_I: begin
                a_p0  = fa_p0;
                b_p0  = bus.imm;
                op_p0 = alu_func(bus.funct3, bus.funct7_5, 1'b0);
            end
            OPC_LOAD, OPC_STORE: begin
                a_p0 = fa_p0;
                b_p0 = bus.imm;
            end
            OPC_BRANCH: begin
                case (bus.funct3)
                    3'b000, 3'b001: op_p0 = OP_SUB;
                    3'b100, 3'b101: op_p0 = OP_SLT;
                    3'b110, 3'b111: op_p0 = OP_SLTU;
                    default:        ill_p0 = 1'b1;
                endcase
                if (!ill_p0) begin
                    a_p0 = fa_p0;
                    b_p0 = fb_p0;
                end
            end
            OPC_LUI:   b_p0 = bus.imm;
            OPC_AUIPC: begin
                a_p0 = bus.pc;
                b_p0 = bus.imm;
            end
            OPC_JAL, OPC_JALR: begin
                a_p0 = bus.pc;
                b_p0 = XLEN'(4);
            end
            default:   ill_p0 = 1'b1;
        endcase
    end

    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign load_p0      = bus.in_valid && bus.in_ready && !bus.flush;
    assign done_p1      = vld_p1 && bus.out_ready && !bus.flush;

    // ---- p1: issue register, frozen while EX stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            a_p1         <= '0;
            b_p1         <= '0;
            sd_p1        <= '0;
            op_p1        <= OP_AND;
            ill_p1       <= 1'b0;
            issue_cnt_p1 <= '0;
        end else begin
            if (bus.flush) begin
                vld_p1 <= 1'b0;
            end else if (load_p0) begin
                vld_p1 <= 1'b1;
                a_p1   <= a_p0;
                b_p1   <= b_p0;
                sd_p1  <= fb_p0;
                op_p1  <= op_p0;
                ill_p1 <= ill_p0;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (done_p1) begin
                issue_cnt_p1 <= issue_cnt_p1 + 32'd1;
            end
        end
    end

    assign bus.out_valid     = vld_p1;
    assign bus.A             = a_p1;
    assign bus.B             = b_p1;
    assign bus.store_data    = sd_p1;
    assign bus.ALU_operation = op_p1;
    assign bus.illegal       = ill_p1;
    assign bus.issue_count   = issue_cnt_p1;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, forwarding, stall, flush,
// counter wrap and asynchronous reset.
module tb_alu_issue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present one instruction at the falling edge and let it load at the next rising edge.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                        input logic [31:0] pcv, input logic [31:0] immv);
        @(negedge clk);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.pc       = pcv;
        bus.imm      = immv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       f75;
        logic [3:0] op;
    } rvec_t;

    rvec_t rtab[10];

    initial begin
        checks = 0;
        errors = 0;
        rtab[0] = '{3'd0, 1'b0, 4'b0010};
        rtab[1] = '{3'd0, 1'b1, 4'b0110};
        rtab[2] = '{3'd1, 1'b0, 4'b1110};
        rtab[3] = '{3'd2, 1'b0, 4'b0111};
        rtab[4] = '{3'd3, 1'b0, 4'b1001};
        rtab[5] = '{3'd4, 1'b0, 4'b1100};
        rtab[6] = '{3'd5, 1'b0, 4'b1101};
        rtab[7] = '{3'd5, 1'b1, 4'b1111};
        rtab[8] = '{3'd6, 1'b0, 4'b0001};
        rtab[9] = '{3'd7, 1'b0, 4'b0000};

        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.opcode     = 7'b0110011;
        bus.funct3     = 3'd0;
        bus.funct7_5   = 1'b0;
        bus.pc         = 32'h0;
        bus.imm        = 32'h0;
        bus.rs1_data   = 32'h8000_0000;
        bus.rs2_data   = 32'h3;
        bus.fwd_a_sel  = 2'b00;
        bus.fwd_b_sel  = 2'b00;
        bus.ex_mem_res = 32'hDEAD_0001;
        bus.mem_wb_res = 32'hDEAD_0002;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_A", bus.A, 32'h0);
        chk("rst_op", 32'(bus.ALU_operation), 32'h0);
        chk("rst_count", bus.issue_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type sweep, back-to-back with EX always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.funct3   = rtab[i].f3;
            bus.funct7_5 = rtab[i].f75;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("r_op%0d", i), 32'(bus.ALU_operation), 32'(rtab[i].op));
            chk($sformatf("r_vld%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("r_in_ready%0d", i), 32'(bus.in_ready), 32'd1);
        end
        chk("r_A", bus.A, 32'h8000_0000);
        chk("r_B", bus.B, 32'h3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("r_drain_vld", 32'(bus.out_valid), 32'd0);
        chk("r_count", bus.issue_count, 32'd10);

        // I/U/J and branch decode
        send(7'b0010011, 3'd0, 1'b1, 32'h0, 32'hFFFF_F800);
        chk("addi_op", 32'(bus.ALU_operation), 32'b0010);
        chk("addi_A", bus.A, 32'h8000_0000);
        chk("addi_B", bus.B, 32'hFFFF_F800);
        send(7'b0010011, 3'd5, 1'b1, 32'h0, 32'h0000_0405);
        chk("srai_op", 32'(bus.ALU_operation), 32'b1111);
        send(7'b0110111, 3'd0, 1'b0, 32'h40, 32'h1234_5000);
        chk("lui_A", bus.A, 32'h0);
        chk("lui_B", bus.B, 32'h1234_5000);
        send(7'b0010111, 3'd0, 1'b0, 32'h200, 32'h1000);
        chk("auipc_A", bus.A, 32'h200);
        chk("auipc_B", bus.B, 32'h1000);
        send(7'b1101111, 3'd0, 1'b0, 32'h100, 32'h7FC);
        chk("jal_A", bus.A, 32'h100);
        chk("jal_B", bus.B, 32'h4);
        chk("jal_op", 32'(bus.ALU_operation), 32'b0010);
        send(7'b1100011, 3'd6, 1'b0, 32'h0, 32'h20);
        chk("bltu_op", 32'(bus.ALU_operation), 32'b1001);
        chk("bltu_B", bus.B, 32'h3);
        chk("bltu_ill", 32'(bus.illegal), 32'd0);
        send(7'b1100011, 3'd0, 1'b0, 32'h0, 32'h20);
        chk("beq_op", 32'(bus.ALU_operation), 32'b0110);
        send(7'b1100011, 3'd2, 1'b0, 32'h0, 32'h20);
        chk("br010_ill", 32'(bus.illegal), 32'd1);
        chk("br010_A", bus.A, 32'h0);
        chk("br010_B", bus.B, 32'h0);
        send(7'h7F, 3'd0, 1'b0, 32'h0, 32'h20);
        chk("opc7f_ill", 32'(bus.illegal), 32'd1);
        chk("opc7f_op", 32'(bus.ALU_operation), 32'b0010);

        // Forwarding
        bus.fwd_a_sel  = 2'b01;
        bus.fwd_b_sel  = 2'b10;
        bus.ex_mem_res = 32'hAA;
        bus.mem_wb_res = 32'h55;
        send(7'b0100011, 3'd2, 1'b0, 32'h0, 32'h10);
        chk("st_A", bus.A, 32'hAA);
        chk("st_B", bus.B, 32'h10);
        chk("st_data", bus.store_data, 32'h55);
        chk("st_ill", 32'(bus.illegal), 32'd0);
        bus.fwd_a_sel = 2'b11;
        bus.fwd_b_sel = 2'b11;
        send(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h0);
        chk("sel11_A", bus.A, 32'h8000_0000);
        chk("sel11_B", bus.B, 32'h3);
        chk("sel11_sd", bus.store_data, 32'h3);
        bus.fwd_a_sel = 2'b00;
        bus.fwd_b_sel = 2'b00;
        @(posedge clk);
        #1;
        chk("ij_count", bus.issue_count, 32'd21);

        // Stall: hold an xor entry while a different instruction waits
        bus.out_ready = 1'b0;
        send(7'b0110011, 3'd4, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        bus.opcode     = 7'b0110011;
        bus.funct3     = 3'd6;
        bus.rs1_data   = 32'h11;
        bus.in_valid   = 1'b1;
        bus.fwd_a_sel  = 2'b01;
        bus.ex_mem_res = 32'h77;
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        bus.fwd_a_sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_op%0d", i), 32'(bus.ALU_operation), 32'b1100);
            chk($sformatf("stall_A%0d", i), bus.A, 32'h8000_0000);
            chk($sformatf("stall_vld%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall_cnt%0d", i), bus.issue_count, 32'd21);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("release_cnt", bus.issue_count, 32'd22);
        chk("release_op", 32'(bus.ALU_operation), 32'b0001);
        chk("release_A", bus.A, 32'h11);
        chk("release_vld", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("release_cnt2", bus.issue_count, 32'd23);

        // Flush drops both the held and the incoming instruction
        bus.out_ready = 1'b0;
        send(7'b0110011, 3'd1, 1'b0, 32'h0, 32'h0);
        chk("pre_flush_vld", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.funct3    = 3'd7;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_vld", 32'(bus.out_valid), 32'd0);
        chk("flush_cnt", bus.issue_count, 32'd23);
        chk("flush_op", 32'(bus.ALU_operation), 32'b1110);

        // Counter wrap
        @(negedge clk);
        force dut.issue_cnt_p1 = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.issue_cnt_p1;
        send(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap_cnt", bus.issue_count, 32'h0);

        // Asynchronous reset while stalled
        bus.out_ready = 1'b0;
        send(7'b0010111, 3'd0, 1'b0, 32'h300, 32'h5);
        chk("prerst_A", bus.A, 32'h300);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bus.out_valid), 32'd0);
        chk("arst_A", bus.A, 32'h0);
        chk("arst_B", bus.B, 32'h0);
        chk("arst_sd", bus.store_data, 32'h0);
        chk("arst_op", 32'(bus.ALU_operation), 32'h0);
        chk("arst_cnt", bus.issue_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
